// File: rtl/data_bus_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
// Port 0 is the CPU load/store path, port 1 the UART loader/peripheral master.
package data_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } owner_t;

    localparam int PORT_CPU  = 0;
    localparam int PORT_UART = 1;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    // Lock state owned by the given port index.
    function automatic owner_t lock_state(input logic port);
        return port ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-request round-robin picker: on a tie, the port that
// was not granted last wins.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0] && (!req_i[1] || last_i)) begin
            gnt_o[0] = 1'b1;
        end else if (req_i[1]) begin
            gnt_o[1] = 1'b1;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the single-ported data memory between the CPU and UART master with
// round-robin fairness, a bounded ownership lock and one-cycle read return.
module data_bus_arbiter
    import data_bus_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_0,
    input  logic              we_0,
    input  logic              lock_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              gnt_0,
    output logic              rvalid_0,
    output logic [DATA_W-1:0] rdata_0,

    input  logic              req_1,
    input  logic              we_1,
    input  logic              lock_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_1,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_1,

    output logic              stall_cpu,

    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    owner_t             owner_q,    owner_d;
    logic               last_q,     last_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               rd_pend_q,  rd_pend_d;
    logic               rd_port_q,  rd_port_d;

    logic [1:0]         req_vec;
    logic [1:0]         pick_req;
    logic [1:0]         pick_gnt;
    logic [1:0]         gnt;
    logic               any_gnt;
    logic               gnt_port;
    logic               sel_lock;
    logic               sel_we;
    logic [CNT_W-1:0]   cnt_inc;

    assign req_vec = {req_1, req_0};

    // A locked owner hides the other requester from the picker.
    always_comb begin
        pick_req = 2'b00;
        unique case (owner_q)
            IDLE:    pick_req = req_vec;
            LOCK0:   pick_req = {1'b0, req_vec[PORT_CPU]};
            LOCK1:   pick_req = {req_vec[PORT_UART], 1'b0};
            default: pick_req = 2'b00;
        endcase
    end

    rr_pick2 u_pick (
        .req_i  (pick_req),
        .last_i (last_q),
        .gnt_o  (pick_gnt)
    );

    // Nothing issues while reset is held.
    assign gnt      = pick_gnt & {2{~rst}};
    assign any_gnt  = |gnt;
    assign gnt_port = gnt[PORT_UART];
    assign sel_lock = gnt_port ? lock_1 : lock_0;
    assign sel_we   = gnt_port ? we_1   : we_0;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous to match the system.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_port_q  <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_port_q  <= rd_port_d;
        end
    end

    // Next-state: grant bookkeeping, lock entry/extension and forced release.
    always_comb begin
        owner_d    = owner_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        rd_pend_d  = 1'b0;
        rd_port_d  = rd_port_q;
        cnt_inc    = (owner_q == IDLE) ? CNT_W'(1) : lock_cnt_q + CNT_W'(1);

        if (any_gnt) begin
            last_d    = gnt_port;
            rd_pend_d = ~sel_we;
            rd_port_d = gnt_port;
            if (sel_lock && (cnt_inc != CNT_W'(MAX_LOCK))) begin
                owner_d    = lock_state(gnt_port);
                lock_cnt_d = cnt_inc;
            end else begin
                owner_d    = IDLE;
                lock_cnt_d = '0;
            end
        end else if (owner_q != IDLE) begin
            // Locked owner dropped its request: give the bus back.
            owner_d    = IDLE;
            lock_cnt_d = '0;
        end
    end

    // Outputs: memory bus mirrors the granted port, responses follow rd_pend.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[PORT_CPU]) begin
            mem_re    = ~we_0;
            mem_we    = we_0;
            mem_addr  = addr_0;
            mem_wdata = wdata_0;
        end else if (gnt[PORT_UART]) begin
            mem_re    = ~we_1;
            mem_we    = we_1;
            mem_addr  = addr_1;
            mem_wdata = wdata_1;
        end
    end

    assign gnt_0     = gnt[PORT_CPU];
    assign gnt_1     = gnt[PORT_UART];
    assign stall_cpu = req_0 & ~gnt_0;

    assign rvalid_0  = rd_pend_q & ~rd_port_q & ~rst;
    assign rvalid_1  = rd_pend_q &  rd_port_q & ~rst;
    assign rdata_0   = rvalid_0 ? mem_rdata : '0;
    assign rdata_1   = rvalid_1 ? mem_rdata : '0;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_data_bus_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_LOCK = 16;

    typedef struct packed {
        logic          req;
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } port_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_0, we_0, lock_0, gnt_0, rvalid_0;
    logic [AW-1:0] addr_0;
    logic [DW-1:0] wdata_0, rdata_0;
    logic          req_1, we_1, lock_1, gnt_1, rvalid_1;
    logic [AW-1:0] addr_1;
    logic [DW-1:0] wdata_1, rdata_1;
    logic          stall_cpu, mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    data_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .we_0(we_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .stall_cpu(stall_cpu),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Read-only memory contents; 0x10 holds the known test word.
    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Memory answers one cycle after mem_re; garbage otherwise.
    always @(posedge clk) mem_rdata <= mem_re ? rom(mem_addr) : 32'h5A5A_5A5A;

    // Reference model state: locked port (-1 = none), last winner, lock run length,
    // and the read whose data is due next cycle.
    int            m_lock_port = -1;
    int            m_last      = 1;
    int            m_cnt       = 0;
    bit            m_pend      = 1'b0;
    int            m_pend_port = 0;
    logic [AW-1:0] m_pend_addr = '0;

    int checks = 0;
    int errors = 0;
    int last_g = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic port_t mk(input logic req, input logic we, input logic lock,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        port_t p;
        p.req = req; p.we = we; p.lock = lock; p.addr = addr; p.wdata = wdata;
        return p;
    endfunction

    // One bus cycle: drive at negedge, compare 1 time unit later, advance model.
    task automatic step(input port_t p0, input port_t p1, input logic r, input bit do_chk);
        int            g;
        int            n;
        port_t         s;
        logic          ev0, ev1;
        logic [DW-1:0] ed0, ed1;
        @(negedge clk);
        rst = r;
        req_0 = p0.req; we_0 = p0.we; lock_0 = p0.lock; addr_0 = p0.addr; wdata_0 = p0.wdata;
        req_1 = p1.req; we_1 = p1.we; lock_1 = p1.lock; addr_1 = p1.addr; wdata_1 = p1.wdata;
        #1;
        g = -1;
        if (!r) begin
            if (m_lock_port < 0) begin
                if (p0.req && p1.req) g = 1 - m_last;
                else if (p0.req)      g = 0;
                else if (p1.req)      g = 1;
            end else if ((m_lock_port == 0) ? p0.req : p1.req) begin
                g = m_lock_port;
            end
        end
        s   = (g == 1) ? p1 : p0;
        ev0 = !r && m_pend && (m_pend_port == 0);
        ev1 = !r && m_pend && (m_pend_port == 1);
        ed0 = ev0 ? rom(m_pend_addr) : '0;
        ed1 = ev1 ? rom(m_pend_addr) : '0;
        if (do_chk) begin
            check("gnt_0",     64'(gnt_0),     64'(g == 0));
            check("gnt_1",     64'(gnt_1),     64'(g == 1));
            check("mem_re",    64'(mem_re),    64'(g >= 0 && !s.we));
            check("mem_we",    64'(mem_we),    64'(g >= 0 && s.we));
            check("mem_addr",  64'(mem_addr),  64'((g >= 0) ? s.addr : '0));
            check("mem_wdata", 64'(mem_wdata), 64'((g >= 0) ? s.wdata : '0));
            check("rvalid_0",  64'(rvalid_0),  64'(ev0));
            check("rvalid_1",  64'(rvalid_1),  64'(ev1));
            check("rdata_0",   64'(rdata_0),   64'(ed0));
            check("rdata_1",   64'(rdata_1),   64'(ed1));
            check("stall_cpu", 64'(stall_cpu), 64'(p0.req && g != 0));
        end
        if (r) begin
            m_lock_port = -1; m_last = 1; m_cnt = 0; m_pend = 1'b0;
        end else if (g >= 0) begin
            m_last = g;
            if (s.lock) begin
                n = (m_lock_port < 0) ? 1 : m_cnt + 1;
                if (n == MAX_LOCK) begin
                    m_lock_port = -1; m_cnt = 0;
                end else begin
                    m_lock_port = g; m_cnt = n;
                end
            end else begin
                m_lock_port = -1; m_cnt = 0;
            end
            m_pend      = !s.we;
            m_pend_port = g;
            m_pend_addr = s.addr;
        end else begin
            if (m_lock_port >= 0) begin
                m_lock_port = -1; m_cnt = 0;
            end
            m_pend = 1'b0;
        end
        last_g = g;
    endtask

    port_t idle_p;
    port_t p0, p1;
    port_t cur[2];
    bit    have[2];
    int    k, run, stall_n;
    bit    cpu_done, seen0;

    initial begin
        idle_p = '0;
        rst = 1'b1;
        req_0 = 0; we_0 = 0; lock_0 = 0; addr_0 = '0; wdata_0 = '0;
        req_1 = 0; we_1 = 0; lock_1 = 0; addr_1 = '0; wdata_1 = '0;

        // Reset, then a single CPU read of 0x10.
        step(idle_p, idle_p, 1'b1, 1'b0);
        step(idle_p, idle_p, 1'b1, 1'b1);
        step(idle_p, idle_p, 1'b0, 1'b1);
        check("reset_stall", 64'(stall_cpu), 64'(0));
        step(mk(1, 0, 0, 32'h10, '0), idle_p, 1'b0, 1'b1);
        check("t1_gnt0", 64'(gnt_0), 64'(1));
        check("t1_addr", 64'(mem_addr), 64'(32'h10));
        step(idle_p, idle_p, 1'b0, 1'b1);
        check("t1_rdata", 64'(rdata_0), 64'(32'hDEAD_BEEF));
        check("t1_rvalid1", 64'(rvalid_1), 64'(0));

        // Tie straight after reset, then alternation while both hold req.
        step(idle_p, idle_p, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(mk(1, 0, 0, 32'h200 + 32'(4 * i), '0), mk(1, 0, 0, 32'h300 + 32'(4 * i), '0), 1'b0, 1'b1);
            check("t2_alternate", 64'(gnt_1), 64'(i % 2));
        end

        // Locked UART write stream against a waiting CPU read.
        step(idle_p, idle_p, 1'b1, 1'b1);
        k = 0; run = 0; stall_n = 0; cpu_done = 0; seen0 = 0;
        for (int i = 0; i < 60 && !(k >= 20 && cpu_done); i++) begin
            p1 = (k < 20) ? mk(1, 1, 1, 32'h100 + 32'(4 * k), 32'(k)) : idle_p;
            p0 = (i >= 1 && !cpu_done) ? mk(1, 0, 0, 32'h40, '0) : idle_p;
            step(p0, p1, 1'b0, 1'b1);
            if (!seen0 && gnt_1) run++;
            if (gnt_0) seen0 = 1;
            if (stall_cpu) stall_n++;
            if (last_g == 1) k++;
            if (last_g == 0) cpu_done = 1;
        end
        check("t3_lock_run", 64'(run), 64'(MAX_LOCK));
        check("t3_stall_cycles", 64'(stall_n), 64'(MAX_LOCK - 1));
        check("t3_cpu_served", 64'(cpu_done), 64'(1));
        step(idle_p, idle_p, 1'b0, 1'b1);

        // Back-to-back reads on different ports.
        step(mk(1, 0, 0, 32'h4, '0), idle_p, 1'b0, 1'b1);
        step(idle_p, mk(1, 0, 0, 32'h8, '0), 1'b0, 1'b1);
        check("t4_rvalid0", 64'(rvalid_0), 64'(1));
        check("t4_rdata0", 64'(rdata_0), 64'(rom(32'h4)));
        check("t4_gnt1", 64'(gnt_1), 64'(1));
        step(idle_p, idle_p, 1'b0, 1'b1);
        check("t4_rdata1", 64'(rdata_1), 64'(rom(32'h8)));

        // Reset right after a read grant drops the response.
        step(mk(1, 0, 0, 32'h30, '0), idle_p, 1'b0, 1'b1);
        step(idle_p, idle_p, 1'b1, 1'b1);
        check("t5_no_rvalid", 64'(rvalid_0), 64'(0));
        step(mk(1, 0, 0, 32'h34, '0), mk(1, 0, 0, 32'h38, '0), 1'b0, 1'b1);
        check("t5_tie_gnt0", 64'(gnt_0), 64'(1));
        step(idle_p, idle_p, 1'b0, 1'b1);

        // Single UART write.
        step(idle_p, mk(1, 1, 0, 32'h20, 32'h1234), 1'b0, 1'b1);
        check("t6_we", 64'(mem_we), 64'(1));
        check("t6_addr", 64'(mem_addr), 64'(32'h20));
        check("t6_wdata", 64'(mem_wdata), 64'(32'h1234));
        step(idle_p, idle_p, 1'b0, 1'b1);
        check("t6_we_done", 64'(mem_we), 64'(0));
        check("t6_no_rvalid", 64'(rvalid_1), 64'(0));

        // Randomized traffic obeying hold-until-grant, with aborts and resets.
        have[0] = 0; have[1] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!have[p]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        have[p] = 1;
                        cur[p] = mk(1, 1'($urandom % 2),
                                    (p == 1) ? 1'($urandom % 2) : 1'($urandom_range(0, 3) == 0),
                                    $urandom & 32'hFFFF_FFFC, $urandom);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    have[p] = 0;
                end
            end
            if ($urandom_range(0, 99) == 0) begin
                step(idle_p, idle_p, 1'b1, 1'b1);
            end else begin
                step(have[0] ? cur[0] : idle_p, have[1] ? cur[1] : idle_p, 1'b0, 1'b1);
                if (last_g >= 0) have[last_g] = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-port arbiter that shares the single-ported data memory between the CPU load/store path and the UART loader/peripheral master. It sits between those requesters and the data memory. Each cycle it decides which requester drives the memory. It routes read data back to the issuing port one cycle later and gives the CPU a stall indication while it waits. Fairness comes from round-robin selection; a bounded lock lets the UART loader stream writes back-to-back.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_LOCK, 16, maximum consecutive grants a locked port may hold before a forced release (≥1)

Ports (x ∈ {0,1}; port 0 = CPU, port 1 = UART master):
- clk  in  1  system clock; everything samples on posedge
- rst  in  1  synchronous, active-high reset
- req_x  in  1  transaction request, held until gnt_x
- we_x  in  1  1 = write, 0 = read
- lock_x  in  1  keep ownership for the following transaction
- addr_x  in  ADDR_W  byte address
- wdata_x  in  DATA_W  write data
- gnt_x  out  1  transaction issued this cycle
- rvalid_x  out  1  read data valid on rdata_x
- rdata_x  out  DATA_W  read data
- stall_cpu  out  1  = req_0 & ~gnt_0
- mem_re, mem_we  out  1  memory read/write strobes
- mem_addr  out  ADDR_W
- mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  valid one cycle after mem_re

## Operation
- State: owner ∈ {IDLE, LOCK0, LOCK1}; last (index of the last granted port); lock_cnt [$clog2(MAX_LOCK+1)]; rd_pend (valid and port index).
- Grant is combinational from req_x and the registered state. At most one gnt per cycle.
- IDLE:
  - If only one port requests, that port is granted.
  - If both request, the port ≠ last is granted.
- LOCKx: only port x can be granted; the other port waits.
- On grant to port x:
  - last ← x.
  - If lock_x=1, go to LOCKx and lock_cnt ← lock_cnt+1 (set to 1 if coming from IDLE). Otherwise go to IDLE and lock_cnt ← 0.
- Release from LOCKx to IDLE:
  - when req_x=0 in LOCKx;
  - or when lock_cnt == MAX_LOCK at a grant to x: the next cycle is IDLE with last=x, so a waiting peer wins.
- The memory bus mirrors the granted port: mem_addr/mem_wdata = addr_x/wdata_x, mem_we = gnt_x & we_x, mem_re = gnt_x & ~we_x. With no grant, mem_re = mem_we = 0 and addr/wdata hold 0.
- Reads: a grant with we=0 sets rd_pend to (1, x). The next cycle, rvalid_x=1 and rdata_x = mem_rdata. Otherwise rdata_x = 0.
- Writes complete at gnt; they produce no response.
- Back-to-back issue is allowed: a new grant may coincide with rvalid for the previous read, including on the same port.

## Timing
- Reset values: owner=IDLE, last=1 (port 0 wins the first tie), lock_cnt=0, rd_pend=0. All gnt, rvalid, mem strobes and stall_cpu are 0 in the cycle after rst, except stall_cpu follows req_0 combinationally.
- Latency:
  - Issue: 0 cycles from req to gnt when uncontended.
  - Read: rvalid exactly 1 cycle after gnt.
  - Throughput: one transaction per cycle.
- Reset mid-operation: a pending read response is dropped (no rvalid) and any lock is cleared.
- Requesters must keep req/addr/we/wdata stable until gnt. Deasserting req without a grant is legal; it is an abort with no side effect.
- Worst-case wait for an unlocked requester: MAX_LOCK+1 cycles.

## Structure
- Package data_bus_pkg holds:
  - owner_t enum (IDLE, LOCK0, LOCK1);
  - constants PORT_CPU=0 and PORT_UART=1;
  - the default ADDR_W/DATA_W.
- Sub-module rr_pick2: combinational two-request round-robin picker (req[1:0], last → gnt[1:0]). It is instantiated once; the lock logic masks its inputs.
- The memory mux, rd_pend and the lock counter live in the top.

## Test plan
- Reset then single CPU read at 0x10, memory returns 0xDEADBEEF → gnt_0 same cycle, mem_re=1, mem_addr=0x10; next cycle rvalid_0=1 with rdata_0=0xDEADBEEF; rvalid_1 stays 0.
- Both ports request reads in the first cycle after reset → gnt_0 first, port 1 granted the following cycle; alternating grants while both hold req.
- UART streams 20 locked writes (lock_1=1) while the CPU requests from cycle 2 → 16 consecutive gnt_1; the next grant is gnt_0; stall_cpu is high during the 15 cycles it waits.
- Back-to-back reads, port 0 to 0x4 then port 1 to 0x8 → in the second cycle rvalid_0 is paired with data for 0x4 while gnt_1 issues; the next cycle gives rvalid_1 with data for 0x8.
- rst asserted in the cycle after a read grant → no rvalid; owner=IDLE; the next tie is granted to port 0.
- Write on port 1 (addr 0x20, data 0x1234) → mem_we=1 for exactly one cycle with matching addr/wdata; no rvalid follows.
